// File: rtl/fm7_irq_pkg.sv
// Shared definitions for the FM-7 style interrupt mask controller.
//   - Bit positions inside the $FD02 mask register
//   - Encoding of the $FD03 read-clear sequencer
package fm7_irq_pkg;

  localparam int KEY_BIT = 0;  // keyboard IRQ enable
  localparam int PRN_BIT = 1;  // printer IRQ enable
  localparam int TMR_BIT = 2;  // timer IRQ enable

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Synchroniser plus falling-edge detector for one asynchronous,
// active-low interrupt source.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset (chain and history reset to 1)
//   din   : asynchronous input
//   fall  : one-cycle pulse, high while the synchronised input has just
//           gone 1->0 relative to its registered history
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Reset leaves history at 1, so a source already low at reset release
  // produces exactly one edge once it has passed the chain.
  assign fall = hist_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_mask_ctrl.sv
// Interrupt mask / status controller for the keyboard, printer and timer
// sources.
//   CLKSYS, RESETBn : system clock, async active-low reset
//   WFD02n          : $FD02 write strobe (mask register)
//   RFD01n          : $FD01 read strobe (keyboard data, clears key IRQ)
//   RFD03n          : $FD03 read strobe (IRQ status, clears printer IRQ
//                     and pulses IRQCLRn towards the timer)
//   MDATABUS_in     : write data
//   KEYSTBn, PRNACKn: asynchronous event inputs, falling edge = event
//   KEYINn, LPINTn  : pending IRQs, active-low
//   TMMASK          : timer mask, 1 = masked
//   IRQCLRn         : one-cycle active-low timer IRQ clear
//   MASK            : current $FD02 contents
module irq_mask_ctrl
  import fm7_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLKSYS,
  input  logic       RESETBn,
  input  logic       WFD02n,
  input  logic       RFD01n,
  input  logic       RFD03n,
  input  logic [7:0] MDATABUS_in,
  input  logic       KEYSTBn,
  input  logic       PRNACKn,
  output logic       KEYINn,
  output logic       LPINTn,
  output logic       TMMASK,
  output logic       IRQCLRn,
  output logic [7:0] MASK
);

  // Strobe history; bus strobes are synchronous to CLKSYS.
  logic wfd02_q, rfd01_q, rfd03_q;
  logic [7:0] data_q;
  logic [7:0] mask_q;
  logic key_q, prn_q;
  clr_state_e state_q, state_d;

  logic wfd02_rel, rfd01_rel, rfd03_asr, rfd03_rel;
  logic key_fall, prn_fall;
  logic key_set, key_clr, prn_set, prn_clr;

  assign wfd02_rel = ~wfd02_q & WFD02n;
  assign rfd01_rel = ~rfd01_q & RFD01n;
  assign rfd03_asr = rfd03_q & ~RFD03n;
  assign rfd03_rel = ~rfd03_q & RFD03n;

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
    .clk   (CLKSYS),
    .rst_n (RESETBn),
    .din   (KEYSTBn),
    .fall  (key_fall)
  );

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_prn_sync (
    .clk   (CLKSYS),
    .rst_n (RESETBn),
    .din   (PRNACKn),
    .fall  (prn_fall)
  );

  // Enables are taken from the current mask, not the one being written.
  assign key_set = key_fall & mask_q[KEY_BIT];
  assign prn_set = prn_fall & mask_q[PRN_BIT];
  assign key_clr = rfd01_rel | (wfd02_rel & ~data_q[KEY_BIT]);
  assign prn_clr = rfd03_rel | (wfd02_rel & ~data_q[PRN_BIT]);

  always_ff @(posedge CLKSYS or negedge RESETBn) begin
    if (!RESETBn) begin
      wfd02_q <= 1'b1;
      rfd01_q <= 1'b1;
      rfd03_q <= 1'b1;
      data_q  <= 8'h00;
      mask_q  <= 8'h00;
      key_q   <= 1'b0;
      prn_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      wfd02_q <= WFD02n;
      rfd01_q <= RFD01n;
      rfd03_q <= RFD03n;
      // Data is held from the access itself; the bus may already have
      // moved on by the time the release is seen.
      if (!WFD02n) data_q <= MDATABUS_in;
      if (wfd02_rel) mask_q <= data_q;
      // Set beats clear so an event coinciding with a clear survives.
      if (key_set)      key_q <= 1'b1;
      else if (key_clr) key_q <= 1'b0;
      if (prn_set)      prn_q <= 1'b1;
      else if (prn_clr) prn_q <= 1'b0;
      state_q <= state_d;
    end
  end

  // A re-assertion seen while in CLEAR is not queued; a fresh assertion
  // edge from IDLE is needed to start the next sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rfd03_asr) state_d = ST_ACCESS;
      ST_ACCESS: if (rfd03_rel) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign IRQCLRn = (state_q != ST_CLEAR);
  assign KEYINn  = ~key_q;
  assign LPINTn  = ~prn_q;
  assign MASK    = mask_q;
  assign TMMASK  = ~mask_q[TMR_BIT];

endmodule

// File: tb/tb_irq_mask_ctrl.sv
// Directed bench for irq_mask_ctrl. Inputs change on the falling clock
// edge; outputs are examined on the falling edge as well, i.e. half a
// cycle after the rising edge that updated them.
module tb_irq_mask_ctrl;

  logic       CLKSYS = 1'b0;
  logic       RESETBn = 1'b0;
  logic       WFD02n = 1'b1, RFD01n = 1'b1, RFD03n = 1'b1;
  logic [7:0] MDATABUS_in = 8'h00;
  logic       KEYSTBn = 1'b1, PRNACKn = 1'b1;
  logic       KEYINn, LPINTn, TMMASK, IRQCLRn;
  logic [7:0] MASK;

  int errors = 0;
  int checks = 0;

  irq_mask_ctrl #(.SYNC_STAGES(2)) dut (
    .CLKSYS      (CLKSYS),
    .RESETBn     (RESETBn),
    .WFD02n      (WFD02n),
    .RFD01n      (RFD01n),
    .RFD03n      (RFD03n),
    .MDATABUS_in (MDATABUS_in),
    .KEYSTBn     (KEYSTBn),
    .PRNACKn     (PRNACKn),
    .KEYINn      (KEYINn),
    .LPINTn      (LPINTn),
    .TMMASK      (TMMASK),
    .IRQCLRn     (IRQCLRn),
    .MASK        (MASK)
  );

  always #5 CLKSYS = ~CLKSYS;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge CLKSYS);
  endtask

  // Stimulus only: 2-cycle write, returns one cycle after the release.
  task automatic write_mask(input logic [7:0] v);
    WFD02n = 1'b0; MDATABUS_in = v;
    cyc(2);
    WFD02n = 1'b1; MDATABUS_in = 8'h00;
    cyc(1);
  endtask

  task automatic test_reset();
    RESETBn = 1'b0;
    cyc(2);
    checks++; if (MASK !== 8'h00) begin errors++; $display("FAIL reset_mask got=%h exp=00", MASK); end
    checks++; if (TMMASK !== 1'b1) begin errors++; $display("FAIL reset_tmmask got=%b exp=1", TMMASK); end
    checks++; if (KEYINn !== 1'b1) begin errors++; $display("FAIL reset_keyinn got=%b exp=1", KEYINn); end
    checks++; if (LPINTn !== 1'b1) begin errors++; $display("FAIL reset_lpintn got=%b exp=1", LPINTn); end
    checks++; if (IRQCLRn !== 1'b1) begin errors++; $display("FAIL reset_irqclrn got=%b exp=1", IRQCLRn); end
    RESETBn = 1'b1;
    cyc(2);
  endtask

  task automatic test_mask_write();
    WFD02n = 1'b0; MDATABUS_in = 8'h05;
    cyc(3);
    // Release with a different bus value: the registered 05 must be used.
    WFD02n = 1'b1; MDATABUS_in = 8'hFF;
    checks++; if (MASK !== 8'h00) begin errors++; $display("FAIL write_early got=%h exp=00", MASK); end
    cyc(1);
    checks++; if (MASK !== 8'h05) begin errors++; $display("FAIL write_mask got=%h exp=05", MASK); end
    checks++; if (TMMASK !== 1'b0) begin errors++; $display("FAIL write_tmmask got=%b exp=0", TMMASK); end
    MDATABUS_in = 8'h00;
    cyc(1);
  endtask

  task automatic test_key_irq();
    write_mask(8'h01);
    KEYSTBn = 1'b0;
    cyc(2);
    checks++; if (KEYINn !== 1'b1) begin errors++; $display("FAIL key_too_early got=%b exp=1", KEYINn); end
    cyc(1);
    checks++; if (KEYINn !== 1'b0) begin errors++; $display("FAIL key_set got=%b exp=0", KEYINn); end
    KEYSTBn = 1'b1;
    RFD01n = 1'b0;
    cyc(2);
    checks++; if (KEYINn !== 1'b0) begin errors++; $display("FAIL key_hold_read got=%b exp=0", KEYINn); end
    RFD01n = 1'b1;
    cyc(1);
    checks++; if (KEYINn !== 1'b1) begin errors++; $display("FAIL key_clear got=%b exp=1", KEYINn); end
    cyc(3);
  endtask

  task automatic test_mask_clear();
    write_mask(8'h01);
    KEYSTBn = 1'b0;
    cyc(4);
    KEYSTBn = 1'b1;
    checks++; if (KEYINn !== 1'b0) begin errors++; $display("FAIL mclr_set got=%b exp=0", KEYINn); end
    write_mask(8'h00);
    checks++; if (KEYINn !== 1'b1) begin errors++; $display("FAIL mclr_clear got=%b exp=1", KEYINn); end
    cyc(3);
  endtask

  task automatic test_masked();
    write_mask(8'h00);
    KEYSTBn = 1'b0; PRNACKn = 1'b0;
    cyc(5);
    checks++; if (KEYINn !== 1'b1) begin errors++; $display("FAIL masked_key got=%b exp=1", KEYINn); end
    checks++; if (LPINTn !== 1'b1) begin errors++; $display("FAIL masked_prn got=%b exp=1", LPINTn); end
    KEYSTBn = 1'b1; PRNACKn = 1'b1;
    cyc(4);
  endtask

  task automatic test_fd03_clear();
    write_mask(8'h02);
    PRNACKn = 1'b0;
    cyc(4);
    PRNACKn = 1'b1;
    checks++; if (LPINTn !== 1'b0) begin errors++; $display("FAIL prn_set got=%b exp=0", LPINTn); end
    RFD03n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++; if (IRQCLRn !== 1'b1) begin errors++; $display("FAIL clr_during_access got=%b exp=1", IRQCLRn); end
    end
    checks++; if (LPINTn !== 1'b0) begin errors++; $display("FAIL prn_hold_read got=%b exp=0", LPINTn); end
    RFD03n = 1'b1;
    cyc(1);
    checks++; if (IRQCLRn !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b exp=0", IRQCLRn); end
    checks++; if (LPINTn !== 1'b1) begin errors++; $display("FAIL prn_clear got=%b exp=1", LPINTn); end
    cyc(1);
    checks++; if (IRQCLRn !== 1'b1) begin errors++; $display("FAIL clr_pulse_end got=%b exp=1", IRQCLRn); end
    cyc(3);
  endtask

  task automatic test_set_wins();
    write_mask(8'h02);
    checks++; if (LPINTn !== 1'b1) begin errors++; $display("FAIL setwin_pre got=%b exp=1", LPINTn); end
    RFD03n = 1'b0;
    cyc(2);
    PRNACKn = 1'b0;
    cyc(2);
    // Synchronised printer edge and RFD03n release hit the same rising edge.
    RFD03n = 1'b1;
    cyc(1);
    checks++; if (LPINTn !== 1'b0) begin errors++; $display("FAIL setwin_lpintn got=%b exp=0", LPINTn); end
    checks++; if (IRQCLRn !== 1'b0) begin errors++; $display("FAIL setwin_irqclrn got=%b exp=0", IRQCLRn); end
    PRNACKn = 1'b1;
    cyc(3);
  endtask

  task automatic test_back_to_back();
    // $FD02 write and $FD03 read overlap exactly; both must take effect.
    WFD02n = 1'b0; RFD03n = 1'b0; MDATABUS_in = 8'hA4;
    cyc(2);
    WFD02n = 1'b1; RFD03n = 1'b1; MDATABUS_in = 8'h00;
    cyc(1);
    checks++; if (MASK !== 8'hA4) begin errors++; $display("FAIL overlap_mask got=%h exp=a4", MASK); end
    checks++; if (IRQCLRn !== 1'b0) begin errors++; $display("FAIL overlap_irqclrn got=%b exp=0", IRQCLRn); end
    checks++; if (TMMASK !== 1'b0) begin errors++; $display("FAIL overlap_tmmask got=%b exp=0", TMMASK); end
    cyc(2);
  endtask

  task automatic test_reset_mid_access();
    write_mask(8'h00);
    WFD02n = 1'b0; RFD03n = 1'b0; MDATABUS_in = 8'h5A;
    cyc(2);
    #2 RESETBn = 1'b0;
    #1;
    checks++; if (MASK !== 8'h00) begin errors++; $display("FAIL rst_mid_mask got=%h exp=00", MASK); end
    cyc(1);
    WFD02n = 1'b1; RFD03n = 1'b1; MDATABUS_in = 8'h00;
    cyc(1);
    RESETBn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++; if (IRQCLRn !== 1'b1) begin errors++; $display("FAIL rst_mid_irqclrn got=%b exp=1", IRQCLRn); end
    end
    checks++; if (MASK !== 8'h00) begin errors++; $display("FAIL rst_mid_nowrite got=%h exp=00", MASK); end
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_mask_write();
    test_key_irq();
    test_mask_clear();
    test_masked();
    test_fd03_clear();
    test_set_wins();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
